// File: rtl/demux_tdm.sv
// Time-division demultiplexer: routes input words into four lane registers and presents them as a frame.
// Optional sticky overwrite flag on port err is compiled in with `define DEMUX_TDM_ERR_EN.
module demux_tdm #(
   parameter int WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               sel_mode,
   input  logic [1:0]         sel,
   output logic [4*WIDTH-1:0] out,
   output logic [3:0]         out_strobe,
   output logic               frame_valid,
   input  logic               frame_ack
`ifdef DEMUX_TDM_ERR_EN
   ,
   output logic               err
`endif
);

   // Handshake: a word moves when in_valid && in_ready; in_ready drops only while a frame is held.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] filled;
   logic [1:0] ptr;
   logic [1:0] lane;
   logic [3:0] lane_oh;
   logic [3:0] new_filled;
   logic       xfer;

   assign in_ready    = (state != HOLD);
   assign frame_valid = (state == HOLD);
   assign xfer        = in_valid && in_ready;
   assign lane        = sel_mode ? ptr : sel;
   assign lane_oh     = 4'b0001 << lane;
   assign new_filled  = filled | lane_oh;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         out        <= '0;
         out_strobe <= 4'b0000;
         filled     <= 4'b0000;
         ptr        <= 2'd0;
      end else begin
         out_strobe <= xfer ? lane_oh : 4'b0000;
         case (state)
            EMPTY, FILL: begin
               if (xfer) begin
                  for (int k = 0; k < 4; k++) begin
                     if (lane_oh[k]) out[k*WIDTH +: WIDTH] <= in;
                  end
                  filled <= new_filled;
                  if (sel_mode) ptr <= ptr + 2'd1;
                  state <= (new_filled == 4'b1111) ? HOLD : FILL;
               end
            end
            HOLD: begin
               // Lane data is kept after release so the consumer may still read it.
               if (frame_ack) begin
                  filled <= 4'b0000;
                  ptr    <= 2'd0;
                  state  <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

`ifdef DEMUX_TDM_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (frame_valid && frame_ack) begin
         err <= 1'b0;
      end else if (xfer && ((filled & lane_oh) != 4'b0000)) begin
         err <= 1'b1;
      end
   end
`endif

endmodule
